bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
// PURPOSE
//   Sequential shift-add-3 (double-dabble) binary-to-BCD converter.
//   Sits between the random/reaction-time value source and the per-digit
//   7-segment decoders. It captures a binary value on a start strobe and
//   produces packed BCD digits plus a one-cycle done pulse.
//   It replaces the wide combinational converter on the display path.
// PARAMETERS
//   BIN_W   15  width of the binary input
//   DIGITS  6   number of BCD digits; bcd_out width = 4*DIGITS
// PORTS
//   CLOCK_50  in   1         system clock; all state changes on rising edge
//   reset     in   1         asynchronous, active-high reset
//   start     in   1         request a conversion; sampled only in IDLE
//   bin_in    in   BIN_W     unsigned value; captured on the accepted start edge
//   busy      out  1         high while a conversion is in progress
//   done      out  1         one-cycle pulse; bcd_out is valid and updated
//   bcd_out   out  4*DIGITS  digit i = bcd_out[4i+3:4i]; digit 0 is least significant
// BEHAVIOUR
//   - Reset (async, active-high): state=IDLE, busy=0, done=0, bcd_out=0,
//     internal shift/count registers=0. Reset mid-conversion aborts the
//     conversion; no done pulse is issued for it.
//   - FSM states: IDLE, CONV.
//     - IDLE -> CONV on an edge E0 with start=1. At E0: bin shift reg <= bin_in,
//       BCD scratch <= 0, iteration count <= 0.
//     - CONV: on each edge E1..E_BIN_W, perform one iteration:
//       (a) add 3 to every scratch digit >= 5;
//       (b) shift {scratch, binreg} left by 1.
//       The count increments on each iteration.
//     - At E_BIN_W (final iteration): bcd_out <= final scratch, done <= 1,
//       state -> IDLE.
//   - Latency: busy=1 for exactly BIN_W cycles (E0..E_BIN_W). done=1 in the
//     single cycle following E_BIN_W; otherwise done=0.
//   - start is ignored while busy. bin_in changes after E0 do not affect
//     the result.
//   - start=1 in the cycle done=1 is accepted (state is IDLE), giving
//     back-to-back conversions with no gap.
//   - bcd_out holds its last result until the next completion. It is not
//     cleared at start. Downstream logic may display it continuously.
//   - Digits above the value's magnitude read 0.
//   - DIGITS*4 must be >= ceil(BIN_W*log10(2)) digits * 4. An elaboration-time
//     $error fires otherwise; no overflow output is provided.
//   - Count register width: $clog2(BIN_W+1).
// CONFIGURATION
//   BCD_BLANK_EN defined:
//     - Adds output port `blank` (out, DIGITS), registered and updated at the
//       same edge as bcd_out; reset value 0.
//     - blank[i]=1 iff digit i and all higher digits are zero, for i>=1.
//     - blank[0] is always 0, so the value 0 shows a single "0".
//     - Drives the decoders' blanking input for leading-zero suppression.
//   BCD_BLANK_EN undefined: port `blank` absent; no blanking logic.
// TESTING
//   1. Reset, then start with bin_in=0 -> busy high 15 cycles, done pulse
//      one cycle, bcd_out=24'h000000.
//   2. start with bin_in=15'd32767 -> done exactly 15 cycles after the
//      start edge; bcd_out=24'h032767.
//   3. start with bin_in=12345; at cycle 5 pulse start with bin_in=999
//      -> second start ignored; bcd_out=24'h012345; exactly one done pulse.
//   4. Hold start=1 with bin_in=9 during the done cycle of a previous
//      conversion -> second conversion begins immediately; 15 cycles later
//      bcd_out=24'h000009.
//   5. Assert reset at cycle 7 of converting 500 -> busy, done and bcd_out
//      go to 0 asynchronously; no done pulse. Restart with 500 -> 24'h000500.
//   6. BCD_BLANK_EN: 305 -> blank=6'b111000; 0 -> blank=6'b111110;
//      32767 -> blank=6'b100000.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Optional leading-zero blanking output enabled by defining BCD_BLANK_EN.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 15,
  parameter int DIGITS = 6
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
`ifdef BCD_BLANK_EN
  output logic [DIGITS-1:0]     blank,
`endif
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  // digits needed ~ ceil(BIN_W * log10(2)), fixed-point approximation
  localparam int NEED = (BIN_W * 30103 + 99999) / 100000;

  if (DIGITS < NEED) begin : g_width_err
    $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
  end

  typedef enum logic {
    S_IDLE,
    S_CONV
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [BIN_W-1:0] r_bin;
  logic [BW-1:0]   r_scr;
  logic [BW-1:0]   w_adj;
  logic [BW-1:0]   w_scr_nxt;
  logic [CW-1:0]   r_cnt;
  logic            w_last;
  logic            r_done;
  logic [BW-1:0]   r_bcd;

  always_comb begin
    w_adj = r_scr;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_scr[4*d +: 4] >= 4'd5)
        w_adj[4*d +: 4] = r_scr[4*d +: 4] + 4'd3;
    end
  end

  assign w_scr_nxt = BW'({w_adj, r_bin[BIN_W-1]});
  assign w_last    = (r_cnt == CW'(BIN_W - 1));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (start)  w_state_nxt = S_CONV;
      S_CONV: if (w_last) w_state_nxt = S_IDLE;
      default:            w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_bin   <= '0;
      r_scr   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_bcd   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bin <= bin_in;
            r_scr <= '0;
            r_cnt <= '0;
          end
        end
        S_CONV: begin
          r_bin <= {r_bin[BIN_W-2:0], 1'b0};
          r_scr <= w_scr_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_bcd  <= w_scr_nxt;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state == S_CONV);
  assign done    = r_done;
  assign bcd_out = r_bcd;

`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] w_blank_nxt;
  logic              w_zero;
  logic [DIGITS-1:0] r_blank;

  // blank[0] stays 0 so a zero value still shows one digit
  always_comb begin
    w_blank_nxt = '0;
    w_zero      = 1'b1;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      w_zero         = w_zero & (w_scr_nxt[4*d +: 4] == 4'd0);
      w_blank_nxt[d] = w_zero;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)
      r_blank <= '0;
    else if (r_state == S_CONV && w_last)
      r_blank <= w_blank_nxt;
  end

  assign blank = r_blank;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomized bench for bin_to_bcd_seq against a cycle-level
// arithmetic reference model.
module tb_bin_to_bcd_seq;

  localparam int BIN_W  = 15;
  localparam int DIGITS = 6;
  localparam int BW     = 4 * DIGITS;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [BIN_W-1:0] bin_in = '0;
  logic             busy;
  logic             done;
  logic [BW-1:0]    bcd_out;
`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] blank;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
`ifdef BCD_BLANK_EN
    .blank    (blank),
`endif
    .bcd_out  (bcd_out)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] to_bcd(input int v);
    logic [BW-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [DIGITS-1:0] to_blank(input int v);
    logic [DIGITS-1:0] b;
    int p;
    b = '0;
    p = 10;
    for (int i = 1; i < DIGITS; i++) begin
      b[i] = (v < p);
      p = p * 10;
    end
    return b;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  // Reference: a conversion occupies BIN_W cycles after the accepting edge
  int                m_rem   = 0;
  int                m_val   = 0;
  logic              m_done  = 1'b0;
  logic [BW-1:0]     m_bcd   = '0;
  logic [DIGITS-1:0] m_blank = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem   <= 0;
      m_done  <= 1'b0;
      m_bcd   <= '0;
      m_blank <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_rem != 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_done  <= 1'b1;
          m_bcd   <= to_bcd(m_val);
          m_blank <= to_blank(m_val);
        end
      end else if (start) begin
        m_rem <= BIN_W;
        m_val <= int'(bin_in);
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(m_rem != 0));
    chk("done", 64'(done), 64'(m_done));
    chk("bcd_out", 64'(bcd_out), 64'(m_bcd));
`ifdef BCD_BLANK_EN
    chk("blank", 64'(blank), 64'(m_blank));
`endif
  end

  // Waits for done after a start edge; noise toggles start while busy
  task automatic wait_done(input bit noise, output int lat,
                           output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      bcnt += int'(busy);
      if (done) begin
        lat = k;
        break;
      end
      start  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bin_in = BIN_W'($urandom);
    end
    start = 1'b0;
    if (lat < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: no done within 25 cycles");
    end
  endtask

  task automatic run(input int v, input logic [BW-1:0] lit,
                     input string nm);
    int lat, bcnt;
    start  = 1'b1;
    bin_in = BIN_W'(v);
    wait_done(1'b0, lat, bcnt);
    chk({nm, "_lat"}, 64'(lat), 64'd16);
    chk({nm, "_busy"}, 64'(bcnt), 64'd15);
    chk({nm, "_lit"}, 64'(bcd_out), 64'(lit));
  endtask

  initial begin
    int lat, bcnt, ndone, v;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_bcd", 64'(bcd_out), 64'd0);
    chk("model_12345", 64'(to_bcd(12345)), 64'h012345);
    chk("model_305", 64'(to_bcd(305)), 64'h000305);
    rst = 1'b0;
    @(negedge clk);

    run(0, 24'h000000, "zero");
`ifdef BCD_BLANK_EN
    chk("blank_0", 64'(blank), 64'b111110);
`endif
    @(negedge clk);
    chk("done_1cyc", 64'(done), 64'd0);
    run(32767, 24'h032767, "max");
`ifdef BCD_BLANK_EN
    chk("blank_max", 64'(blank), 64'b100000);
`endif
    run(305, 24'h000305, "v305");
`ifdef BCD_BLANK_EN
    chk("blank_305", 64'(blank), 64'b111000);
`endif

    // start during busy is ignored
    start  = 1'b1;
    bin_in = 15'd12345;
    ndone  = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      ndone += int'(done);
      start  = (k == 5);
      bin_in = (k == 5) ? 15'd999 : 15'd0;
    end
    start = 1'b0;
    chk("ign_bcd", 64'(bcd_out), 64'h012345);
    chk("ign_ndone", 64'(ndone), 64'd1);

    // back-to-back: start held in the done cycle
    start  = 1'b1;
    bin_in = 15'd4321;
    wait_done(1'b0, lat, bcnt);
    chk("b2b_first", 64'(bcd_out), 64'h004321);
    start  = 1'b1;
    bin_in = 15'd9;
    wait_done(1'b0, lat, bcnt);
    chk("b2b_lat", 64'(lat), 64'd16);
    chk("b2b_bcd", 64'(bcd_out), 64'h000009);

    // async reset mid-conversion
    start  = 1'b1;
    bin_in = 15'd500;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_bcd", 64'(bcd_out), 64'd0);
    @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      ndone += int'(done);
    end
    chk("arst_nodone", 64'(ndone), 64'd0);
    run(500, 24'h000500, "v500");

    // random conversions, some back-to-back, noisy start while busy
    for (int n = 0; n < 40; n++) begin
      v      = int'($urandom_range(0, 32767));
      start  = 1'b1;
      bin_in = BIN_W'(v);
      wait_done(1'($urandom_range(0, 1)), lat, bcnt);
      chk("rnd_lat", 64'(lat), 64'd16);
      chk("rnd_bcd", 64'(bcd_out), 64'(to_bcd(v)));
      if ($urandom_range(0, 1) == 0) begin
        @(negedge clk);
        start = 1'b0;
      end
    end
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
